// File: rtl/wb_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// wb_rr_arbiter_if
// Classic Wishbone bus bundle used on each port of wb_rr_arbiter. Signal
// names are seen from the bus master's side:
//   cyc, stb, we  : cycle, strobe and write enable (master -> slave)
//   adr           : address                        (master -> slave)
//   o_dat         : write data                     (master -> slave)
//   sel           : byte selects                   (master -> slave)
//   i_dat         : read data                      (slave  -> master)
//   ack, err      : transfer response              (slave  -> master)
// Modports:
//   master : drives the request and receives the response
//   slave  : receives the request and drives the response
// ---------------------------------------------------------------------------
interface wb_rr_arbiter_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16,
  parameter int SEL_W  = 2
) ();
  logic              cyc;
  logic              stb;
  logic              we;
  logic [ADDR_W-1:0] adr;
  logic [DATA_W-1:0] o_dat;
  logic [SEL_W-1:0]  sel;
  logic [DATA_W-1:0] i_dat;
  logic              ack;
  logic              err;

  modport master (
    output cyc, stb, we, adr, o_dat, sel,
    input  i_dat, ack, err
  );

  modport slave (
    input  cyc, stb, we, adr, o_dat, sel,
    output i_dat, ack, err
  );
endinterface

// File: rtl/wb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// wb_rr_arbiter
// Two-master to one-slave Wishbone arbiter for the 16-bit system bus.
// Master 0 is the CPU-side bus, master 1 a secondary master (DMA/debug).
// The grant is round-robin on ties and is held for the whole bus cycle
// (while the owner keeps cyc high). A watchdog aborts a transfer that has
// waited TIMEOUT cycles for a response by giving the owner a one-cycle err.
//
// Ports:
//   i_clk    system clock
//   i_rst    asynchronous reset, active-high
//   m0, m1   slave-side Wishbone ports facing the two masters
//   s        master-side Wishbone port facing the shared slave
//   o_owner  current grant holder (valid when o_busy)
//   o_busy   a grant is active
// Parameters:
//   ADDR_W, DATA_W, SEL_W  bus widths
//   TIMEOUT                stalled cycles before abort; 0 disables watchdog
// ---------------------------------------------------------------------------
module wb_rr_arbiter #(
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 16,
  parameter int SEL_W   = 2,
  parameter int TIMEOUT = 255
) (
  input  logic             i_clk,
  input  logic             i_rst,
  wb_rr_arbiter_if.slave   m0,
  wb_rr_arbiter_if.slave   m1,
  wb_rr_arbiter_if.master  s,
  output logic             o_owner,
  output logic             o_busy
);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_GRANTED = 1'b1;

  // A zero-width counter is illegal, so a disabled watchdog keeps one bit.
  localparam int              CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [0:0]       busy_q, busy_d;
  logic             owner_q, owner_d;
  logic             last_owner_q, last_owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             abort_q, abort_d;

  logic own_cyc, own_stb, oth_cyc, stalled;
  logic m0_gnt, m1_gnt;

  assign own_cyc = owner_q ? m1.cyc : m0.cyc;
  assign own_stb = owner_q ? m1.stb : m0.stb;
  assign oth_cyc = owner_q ? m0.cyc : m1.cyc;

  // The abort cycle itself is not counted: the slave is not being driven.
  assign stalled = own_stb & ~s.ack & ~s.err & ~abort_q;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    busy_d       = busy_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cnt_d        = '0;
    abort_d      = 1'b0;

    if (busy_q == ST_IDLE) begin
      // last_owner loses a tie, giving strict alternation under contention.
      if (m0.cyc && m1.cyc) begin
        busy_d  = ST_GRANTED;
        owner_d = ~last_owner_q;
      end else if (m0.cyc) begin
        busy_d  = ST_GRANTED;
        owner_d = 1'b0;
      end else if (m1.cyc) begin
        busy_d  = ST_GRANTED;
        owner_d = 1'b1;
      end
    end else if (!own_cyc) begin
      // Release: hand over directly if the other master is waiting. The
      // owner's cyc-low cycle already gives the slave one dead cycle.
      last_owner_d = owner_q;
      if (oth_cyc) begin
        owner_d = ~owner_q;
      end else begin
        busy_d = ST_IDLE;
      end
    end else if (TIMEOUT > 0 && stalled) begin
      if (cnt_q == CNT_MAX) begin
        abort_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      busy_q       <= ST_IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      cnt_q        <= '0;
      abort_q      <= 1'b0;
    end else begin
      busy_q       <= busy_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
      abort_q      <= abort_d;
    end
  end

  // Slave side: request muxed from the owner, forced low when idle and
  // cyc/stb forced low during the abort cycle.
  assign s.cyc   = busy_q[0] & own_cyc & ~abort_q;
  assign s.stb   = busy_q[0] & own_stb & ~abort_q;
  assign s.we    = busy_q[0] & (owner_q ? m1.we : m0.we);
  assign s.adr   = busy_q[0] ? (owner_q ? m1.adr   : m0.adr)   : '0;
  assign s.o_dat = busy_q[0] ? (owner_q ? m1.o_dat : m0.o_dat) : '0;
  assign s.sel   = busy_q[0] ? (owner_q ? m1.sel   : m0.sel)   : '0;

  // Master side: only the owner sees the response; a slave ack during the
  // abort cycle is dropped.
  assign m0_gnt = busy_q[0] & ~owner_q;
  assign m1_gnt = busy_q[0] &  owner_q;

  assign m0.i_dat = m0_gnt ? s.i_dat : '0;
  assign m0.ack   = m0_gnt & s.ack & ~abort_q;
  assign m0.err   = m0_gnt & (s.err | abort_q);

  assign m1.i_dat = m1_gnt ? s.i_dat : '0;
  assign m1.ack   = m1_gnt & s.ack & ~abort_q;
  assign m1.err   = m1_gnt & (s.err | abort_q);

  assign o_owner = owner_q;
  assign o_busy  = busy_q[0];

endmodule
